uart_instr_loader: RTL and testbench
====================================

# uart_instr_loader

UART-driven instruction-memory writer for the tiny FSM control path. It receives 8N1 serial bytes on `uart_rx` and parses a framed load packet. It assembles little-endian instruction words and issues single-cycle writes into the instruction memory that `tiny_fsm_control` reads from. While `busy` is high, the control FSM must be held in reset or halted.

## Interface
Parameters:
- `INSTR_WIDTH`, 32: instruction word width; must be a multiple of 8; `BYTES = INSTR_WIDTH/8`.
- `INSTR_DEPTH`, 256: instruction memory depth; `AW = $clog2(INSTR_DEPTH)`, with `AW <= 8`.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); minimum 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `uart_rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  AW  write address.
- `wr_data`  out  INSTR_WIDTH  write data.
- `busy`  out  1  frame in progress (header accepted, frame not yet terminated).
- `done`  out  1  one-cycle pulse on successful frame completion.
- `err`  out  1  sticky error flag.
- `words_loaded`  out  8  words written in the current or last frame.

## Operation
- Every output resets to 0. Reset mid-frame aborts the frame and issues no further writes.
- RX front end:
  - `uart_rx` passes through a 2-flop synchronizer.
  - Start bit: a high-to-low transition while the RX engine is idle.
  - The line is re-sampled at `CLKS_PER_BIT/2`. If it is high, the event is a glitch: return to idle with no byte.
  - 8 data bits are sampled LSB first, each `CLKS_PER_BIT` apart, at mid-bit.
  - The stop bit is sampled at mid-bit. High produces an internal `byte_vld` strobe. Low is a framing error: set `err`, and the parser returns to P_HDR.
- Frame format: `0xA5`, start address byte, word-count byte N, then N×BYTES data bytes (LS byte first). With `LOADER_CHECKSUM_EN` defined, one checksum byte follows.
- Parser states and transitions:
  - P_HDR: non-0xA5 bytes are ignored. On 0xA5: clear `err` and `words_loaded`, set `busy`, go to P_ADDR.
  - P_ADDR: latch the low AW bits of the byte into `wr_addr`; go to P_CNT.
  - P_CNT: latch N. If N == 0, go to finish (no writes). Otherwise go to P_DATA.
  - P_DATA: shift bytes into the word register.
    - After BYTES bytes: pulse `wr_en` and increment `words_loaded`.
    - `wr_addr` advances by 1 after each write, wrapping from INSTR_DEPTH−1 to 0.
    - After N words, go to P_CSUM (macro defined) or finish.
  - Finish: pulse `done`, drop `busy`, return to P_HDR.
- A framing error in any state other than P_HDR:
  - sets `err` and drops `busy`;
  - returns to P_HDR;
  - commits no partial word.
- Words already written remain written.
- A new 0xA5 is only recognized in P_HDR; inside a frame it is treated as data.

## Timing
- `byte_vld` is asserted in the cycle the stop bit is sampled.
- `wr_en` is asserted exactly 1 cycle after the `byte_vld` of each word's last byte. `wr_addr`/`wr_data` are valid in the same cycle.
- `wr_addr` updates in the cycle after `wr_en`.
- `done` is asserted 1 cycle after the final `wr_en` (or after the count/checksum byte's `byte_vld` when N == 0 or the macro is defined). `busy` falls in the same cycle `done` rises.
- `busy` rises 1 cycle after the header's `byte_vld`.
- `err` rises 1 cycle after the bad stop-bit sample.
- Back-to-back bytes (stop bit followed immediately by a start bit) are accepted; the RX engine is idle-ready within 1 cycle after the stop-bit sample.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - the parser expects a trailing byte equal to the XOR of all data bytes;
  - on match: `done` pulses;
  - on mismatch: `err` is set, `busy` drops, and `done` is not pulsed. Writes already issued stand.
- `LOADER_CHECKSUM_EN` not defined: there is no checksum byte and the frame ends after the last data word.

## Test plan
Bench uses `CLKS_PER_BIT=16`.
- Basic load: send A5 10 02 01 00 00 80 02 00 00 40 -> exactly 2 `wr_en` pulses: (0x10, 0x80000001) then (0x11, 0x40000002); `done` pulses once; `words_loaded`=2; `err`=0; `busy` low after.
- Resync and zero count: send 00 FF 3C, then A5 20 00 -> no writes for 00 FF 3C; `done` pulses with `words_loaded`=0; `wr_addr`=0x20.
- Wrap-around and glitch: 1 A5 FF 02 frame with 8 data bytes -> writes to 0xFF then 0x00. Then drive a 4-cycle low pulse on `uart_rx` -> no byte, no state change.
- Framing error: stop bit forced low during the 3rd data byte -> `err`=1, `busy`=0, no write. A following valid frame -> `err` clears on its header and the frame loads normally.
- Reset mid-frame: assert `rst_n`=0 after A5 10 01 01 00 -> all outputs 0. The remaining bytes 00 80 produce no write.
- With `LOADER_CHECKSUM_EN`: A5 00 01 01 00 00 80 81 -> write 0x80000001 then `done`. Repeating the frame with checksum 00 -> write occurs, `err`=1, no `done`.

Source files
------------

// File: rtl/uart_instr_loader.sv
// UART (8N1) framed loader that writes little-endian instruction words into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_instr_loader #(
    parameter int INSTR_WIDTH  = 32,
    parameter int INSTR_DEPTH  = 256,
    parameter int CLKS_PER_BIT = 434,
    localparam int AW          = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             words_loaded
);

    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0]  HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [7:0]     HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_ADDR, P_CNT, P_DATA, P_CSUM, P_FIN} p_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      rx_shift_q;
    logic            byte_vld_q, frame_err_q;

    p_state_t        p_state_q;
    logic            wr_en_q, busy_q, done_q, err_q;
    logic [AW-1:0]   wr_addr_q;
    logic [INSTR_WIDTH-1:0] wr_data_q;
    logic [7:0]      words_q, cnt_n_q;
    logic [BCW-1:0]  byte_idx_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum_q;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == AW'(INSTR_DEPTH - 1)) begin
            return '0;
        end else begin
            return a + AW'(1);
        end
    endfunction

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit-timing engine: mid-bit sampling, byte strobe or framing error on the stop bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q  <= R_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (rx_state_q)
                R_IDLE: begin
                    clk_cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= R_START;
                    end
                end
                R_START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= 3'd0;
                        // A line that is high again at mid-start was only a glitch
                        rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (clk_cnt_q == BIT_M1) begin
                        clk_cnt_q  <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= R_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                R_STOP: begin
                    if (clk_cnt_q == BIT_M1) begin
                        clk_cnt_q   <= '0;
                        byte_vld_q  <= rx_sync_q;
                        frame_err_q <= !rx_sync_q;
                        rx_state_q  <= R_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    // Frame parser with registered write/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_state_q  <= P_HDR;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 8'h00;
            cnt_n_q    <= 8'h00;
            byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (wr_en_q) begin
                wr_addr_q <= next_addr(wr_addr_q);
            end
            if (frame_err_q) begin
                // Partial word is simply abandoned; completed writes stand
                err_q     <= 1'b1;
                busy_q    <= 1'b0;
                p_state_q <= P_HDR;
            end else begin
                case (p_state_q)
                    P_HDR: begin
                        if (byte_vld_q && (rx_shift_q == HDR_BYTE)) begin
                            err_q     <= 1'b0;
                            words_q   <= 8'h00;
                            busy_q    <= 1'b1;
                            p_state_q <= P_ADDR;
                        end
                    end
                    P_ADDR: begin
                        if (byte_vld_q) begin
                            wr_addr_q <= rx_shift_q[AW-1:0];
                            p_state_q <= P_CNT;
                        end
                    end
                    P_CNT: begin
                        if (byte_vld_q) begin
                            cnt_n_q    <= rx_shift_q;
                            byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum_q     <= 8'h00;
`endif
                            if (rx_shift_q == 8'h00) begin
                                done_q    <= 1'b1;
                                busy_q    <= 1'b0;
                                p_state_q <= P_HDR;
                            end else begin
                                p_state_q <= P_DATA;
                            end
                        end
                    end
                    P_DATA: begin
                        if (byte_vld_q) begin
                            wr_data_q[{byte_idx_q, 3'b000} +: 8] <= rx_shift_q;
`ifdef LOADER_CHECKSUM_EN
                            csum_q <= csum_fold(csum_q, rx_shift_q);
`endif
                            if (byte_idx_q == LAST_BYTE) begin
                                byte_idx_q <= '0;
                                wr_en_q    <= 1'b1;
                                words_q    <= words_q + 8'd1;
                                if ((words_q + 8'd1) == cnt_n_q) begin
`ifdef LOADER_CHECKSUM_EN
                                    p_state_q <= P_CSUM;
`else
                                    p_state_q <= P_FIN;
`endif
                                end
                            end else begin
                                byte_idx_q <= byte_idx_q + BCW'(1);
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    P_CSUM: begin
                        if (byte_vld_q) begin
                            busy_q    <= 1'b0;
                            p_state_q <= P_HDR;
                            if (rx_shift_q == csum_q) begin
                                done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
`endif
                    P_FIN: begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        p_state_q <= P_HDR;
                    end
                    default: p_state_q <= P_HDR;
                endcase
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Self-checking bench for uart_instr_loader: directed frames plus randomized frames
// checked against a frame-level model (expected addresses/words from the byte list).
module tb_uart_instr_loader;

    localparam int CPB   = 16;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;
    logic [7:0]  words_loaded;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    logic [7:0]  act_addr[$];
    logic [31:0] act_data[$];
    logic [7:0]  dat[$];

    uart_instr_loader #(
        .INSTR_WIDTH(32),
        .INSTR_DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx(uart_rx),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write and done pulse away from the active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && wr_en) begin
            act_addr.push_back(wr_addr);
            act_data.push_back(wr_data);
            last_wr_cyc <= cyc;
        end
        if (rst_n && done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (bad_stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    // Send a full frame using dat[] as payload and compare against the frame model
    task automatic load_frame(input logic [7:0] addr, input int n);
        int wbase;
        int dbase;
        logic [31:0] e;
        logic [7:0]  ea;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) cs = cs ^ dat[i];
`endif
        wbase = act_addr.size();
        dbase = done_cnt;
        send_byte(8'hA5, 1'b0);
        chk("busy_hdr", busy, 1);
        chk("err_hdr", err, 0);
        send_byte(addr, 1'b0);
        send_byte(8'(n), 1'b0);
        for (int i = 0; i < 4 * n; i++) send_byte(dat[i], 1'b0);
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) send_byte(cs, 1'b0);
`endif
        repeat (4) @(negedge clk);
        chk("nwr", act_addr.size() - wbase, n);
        for (int w = 0; w < n; w++) begin
            if (wbase + w < act_addr.size()) begin
                ea = 8'((int'(addr) + w) % DEPTH);
                for (int k = 0; k < 4; k++) e[8*k +: 8] = dat[4*w + k];
                chk("waddr", act_addr[wbase + w], ea);
                chk("wdata", act_data[wbase + w], e);
            end
        end
        chk("done_cnt", done_cnt - dbase, 1);
        chk("err", err, 0);
        chk("busy", busy, 0);
        chk("words", words_loaded, n);
        chk("addr_end", wr_addr, (int'(addr) + n) % DEPTH);
`ifndef LOADER_CHECKSUM_EN
        if (n > 0) chk("done_lat", done_cyc - last_wr_cyc, 1);
`endif
    endtask

    initial begin
        int wb;
        int db;
        int n;
        logic [7:0] a;
        logic [7:0] g;

        repeat (5) @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic load
        dat.delete();
        dat = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h02, 8'h00, 8'h00, 8'h40};
        load_frame(8'h10, 2);

        // Resync through junk, then zero-count frame
        wb = act_addr.size();
        db = done_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        chk("junk_nwr", act_addr.size() - wb, 0);
        chk("junk_done", done_cnt - db, 0);
        chk("junk_busy", busy, 0);
        dat.delete();
        load_frame(8'h20, 0);

        // Address wrap, then a short glitch
        dat.delete();
        for (int i = 0; i < 8; i++) dat.push_back(8'($urandom));
        load_frame(8'hFF, 2);
        wb = act_addr.size();
        db = done_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_nwr", act_addr.size() - wb, 0);
        chk("glitch_done", done_cnt - db, 0);
        chk("glitch_busy", busy, 0);
        chk("glitch_err", err, 0);
        chk("glitch_addr", wr_addr, 8'h01);

        // Framing error on the 3rd data byte
        wb = act_addr.size();
        db = done_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        chk("ferr_err", err, 1);
        chk("ferr_busy", busy, 0);
        chk("ferr_nwr", act_addr.size() - wb, 0);
        chk("ferr_done", done_cnt - db, 0);
        dat.delete();
        for (int i = 0; i < 4; i++) dat.push_back(8'($urandom));
        load_frame(8'h40, 1);

        // Reset in the middle of a frame
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        wb = act_addr.size();
        db = done_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'h80, 1'b0);
        repeat (4) @(negedge clk);
        chk("midrst_nwr", act_addr.size() - wb, 0);
        chk("midrst_done", done_cnt - db, 0);
        chk("midrst_busy", busy, 0);

`ifdef LOADER_CHECKSUM_EN
        dat.delete();
        dat = '{8'h01, 8'h00, 8'h00, 8'h80};
        load_frame(8'h00, 1);
        wb = act_addr.size();
        db = done_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(dat[i], 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        chk("csum_nwr", act_addr.size() - wb, 1);
        if (act_addr.size() > wb) chk("csum_wdata", act_data[wb], 32'h80000001);
        chk("csum_err", err, 1);
        chk("csum_done", done_cnt - db, 0);
        chk("csum_busy", busy, 0);
`endif

        // Randomized frames preceded by random non-header junk
        for (int f = 0; f < 5; f++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1'b0);
            a = 8'($urandom);
            n = $urandom_range(1, 4);
            dat.delete();
            for (int i = 0; i < 4 * n; i++) dat.push_back(8'($urandom));
            load_frame(a, n);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
